// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the unified-memory arbiter.
//   state_t : arbiter FSM encoding (IDLE/ACCESS/WAIT/RESP)
//   P_CPU   : port index of the MIPS multicycle core
//   P_DMA   : port index of the DMA/program loader
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req0, req1 : requests from port 0 / port 1
//   last       : port granted most recently
//   valid      : at least one request present
//   winner     : selected port index (P_CPU or P_DMA)
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = P_CPU;
    if (req0 && req1)
      winner = (last == P_CPU) ? P_DMA : P_CPU;
    else if (req1)
      winner = P_DMA;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-write memory port between the core
// (port 0) and the DMA/loader (port 1) with round-robin arbitration.
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   req/we/adr/wd[01]   : requester access (held until gnt)
//   gnt[01], rvalid[01] : one-cycle grant and read-data-valid pulses
//   rdata               : shared read data, qualified by rvalid0/rvalid1
//   mem_adr/mem_wd/mem_we/mem_rd : memory port
//   busy                : arbiter not in IDLE
// Optional build macro MEM_ARBITER_STATS_EN adds saturating counters
//   gcnt0, gcnt1 (grants per port) and conflict (IDLE cycles with both req).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] gcnt0,
  output logic [CNT_W-1:0] gcnt1,
  output logic [CNT_W-1:0] conflict
`endif
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t        state;
  logic          sel;
  logic          last;
  logic [CW-1:0] cnt;
  logic          valid;
  logic          winner;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (valid),
    .winner (winner)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= P_CPU;
      last    <= P_DMA;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= '0;
      mem_adr <= '0;
      mem_wd  <= '0;
      mem_we  <= 1'b0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      mem_we  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (valid) begin
            // mem_adr/mem_wd double as the latched request; mem_we carries
            // the latched write flag for exactly the ACCESS cycle.
            sel     <= winner;
            last    <= winner;
            mem_adr <= (winner == P_DMA) ? adr1 : adr0;
            mem_wd  <= (winner == P_DMA) ? wd1  : wd0;
            mem_we  <= (winner == P_DMA) ? we1  : we0;
            gnt0    <= (winner == P_CPU);
            gnt1    <= (winner == P_DMA);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_we) begin
            state <= IDLE;
          end else if (RD_LAT == 0) begin
            rdata   <= mem_rd;
            rvalid0 <= (sel == P_CPU);
            rvalid1 <= (sel == P_DMA);
            state   <= RESP;
          end else begin
            cnt   <= CW'(RD_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata   <= mem_rd;
            rvalid0 <= (sel == P_CPU);
            rvalid1 <= (sel == P_DMA);
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      gcnt0    <= '0;
      gcnt1    <= '0;
      conflict <= '0;
    end else if (state == IDLE) begin
      if (valid && (winner == P_CPU) && (gcnt0 != '1))
        gcnt0 <= gcnt0 + 1'b1;
      if (valid && (winner == P_DMA) && (gcnt1 != '1))
        gcnt1 <= gcnt1 + 1'b1;
      if (req0 && req1 && (conflict != '1))
        conflict <= conflict + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench. Instance A uses RD_LAT=0, instance B
// uses RD_LAT=3; each has its own small memory model. Build with
// MEM_ARBITER_STATS_EN defined to also exercise the statistics counters.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A (RD_LAT = 0) ----------------
  logic        rstA, q0A, q1A, w0A, w1A;
  logic [31:0] a0A, a1A, d0A, d1A;
  logic        g0A, g1A, v0A, v1A, mweA, busyA;
  logic [31:0] rdA, madrA, mwdA, mrdA;
  logic [31:0] memA [0:255];
`ifdef MEM_ARBITER_STATS_EN
  logic [1:0]  gc0A, gc1A, cfA;
`endif

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(0), .CNT_W(2)) dutA (
    .clk(clk), .reset(rstA),
    .req0(q0A), .req1(q1A), .we0(w0A), .we1(w1A),
    .adr0(a0A), .adr1(a1A), .wd0(d0A), .wd1(d1A),
    .gnt0(g0A), .gnt1(g1A), .rvalid0(v0A), .rvalid1(v1A),
    .rdata(rdA), .mem_adr(madrA), .mem_wd(mwdA), .mem_we(mweA),
    .mem_rd(mrdA), .busy(busyA)
`ifdef MEM_ARBITER_STATS_EN
    , .gcnt0(gc0A), .gcnt1(gc1A), .conflict(cfA)
`endif
  );

  assign mrdA = memA[madrA[9:2]];
  always @(posedge clk) begin
    if (rstA) memA[16] <= 32'h8C22_0004;
    else if (mweA) memA[madrA[9:2]] <= mwdA;
  end

  // ---------------- instance B (RD_LAT = 3) ----------------
  logic        rstB, q0B, q1B, w0B, w1B;
  logic [31:0] a0B, a1B, d0B, d1B;
  logic        g0B, g1B, v0B, v1B, mweB, busyB;
  logic [31:0] rdB, madrB, mwdB, mrdB;
  logic [31:0] memB [0:255];
`ifdef MEM_ARBITER_STATS_EN
  logic [1:0]  gc0B, gc1B, cfB;
`endif

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .CNT_W(2)) dutB (
    .clk(clk), .reset(rstB),
    .req0(q0B), .req1(q1B), .we0(w0B), .we1(w1B),
    .adr0(a0B), .adr1(a1B), .wd0(d0B), .wd1(d1B),
    .gnt0(g0B), .gnt1(g1B), .rvalid0(v0B), .rvalid1(v1B),
    .rdata(rdB), .mem_adr(madrB), .mem_wd(mwdB), .mem_we(mweB),
    .mem_rd(mrdB), .busy(busyB)
`ifdef MEM_ARBITER_STATS_EN
    , .gcnt0(gc0B), .gcnt1(gc1B), .conflict(cfB)
`endif
  );

  assign mrdB = memB[madrB[9:2]];
  always @(posedge clk) begin
    if (rstB) begin
      memB[16] <= 32'h8C22_0004;
      memB[32] <= 32'h0BAD_F00D;
    end else if (mweB) memB[madrB[9:2]] <= mwdB;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] last_rd;

  // One access on instance A with exact cycle-by-cycle expectations.
  task automatic access_a(input int idx, input vec_t v);
    @(negedge clk);
    q0A = (v.port == 1'b0); q1A = (v.port == 1'b1);
    w0A = v.we; w1A = v.we; a0A = v.adr; a1A = v.adr; d0A = v.wd; d1A = v.wd;
    @(negedge clk);  // ACCESS cycle
    chk($sformatf("v%0d_gnt", idx), {30'd0, g1A, g0A}, v.port ? 32'd2 : 32'd1);
    chk($sformatf("v%0d_mem_adr", idx), madrA, v.adr);
    chk($sformatf("v%0d_mem_we", idx), {31'd0, mweA}, {31'd0, v.we});
    if (v.we) chk($sformatf("v%0d_mem_wd", idx), mwdA, v.wd);
    chk($sformatf("v%0d_busy", idx), {31'd0, busyA}, 32'd1);
    q0A = 1'b0; q1A = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_gnt_pulse", idx), {30'd0, g1A, g0A}, 32'd0);
    chk($sformatf("v%0d_we_low", idx), {31'd0, mweA}, 32'd0);
    if (v.we) begin
      chk($sformatf("v%0d_wr_idle", idx), {31'd0, busyA}, 32'd0);
      chk($sformatf("v%0d_wr_no_rvalid", idx), {30'd0, v1A, v0A}, 32'd0);
      chk($sformatf("v%0d_rdata_hold", idx), rdA, last_rd);
    end else begin
      chk($sformatf("v%0d_rvalid", idx), {30'd0, v1A, v0A}, v.port ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_rdata", idx), rdA, v.exp);
      last_rd = v.exp;
      @(negedge clk);
      chk($sformatf("v%0d_rd_idle", idx), {31'd0, busyA}, 32'd0);
      chk($sformatf("v%0d_rvalid_pulse", idx), {30'd0, v1A, v0A}, 32'd0);
    end
  endtask

  task automatic reset_a();
    @(negedge clk); rstA = 1'b1;
    @(negedge clk); rstA = 1'b0;
    last_rd = 32'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   seen;
    logic got;
    rstA = 1'b1; q0A = 0; q1A = 0; w0A = 0; w1A = 0; a0A = 0; a1A = 0; d0A = 0; d1A = 0;
    rstB = 1'b1; q0B = 0; q1B = 0; w0B = 0; w1B = 0; a0B = 0; a1B = 0; d0B = 0; d1B = 0;
    last_rd = 32'd0;

    tbl[0] = '{port: 1'b0, we: 1'b0, adr: 32'h40, wd: 32'h0,         exp: 32'h8C22_0004};
    tbl[1] = '{port: 1'b1, we: 1'b1, adr: 32'h80, wd: 32'hDEAD_BEEF, exp: 32'h0};
    tbl[2] = '{port: 1'b0, we: 1'b0, adr: 32'h80, wd: 32'h0,         exp: 32'hDEAD_BEEF};
    tbl[3] = '{port: 1'b0, we: 1'b1, adr: 32'h10, wd: 32'h1234_5678, exp: 32'h0};
    tbl[4] = '{port: 1'b1, we: 1'b0, adr: 32'h10, wd: 32'h0,         exp: 32'h1234_5678};
    tbl[5] = '{port: 1'b1, we: 1'b0, adr: 32'h40, wd: 32'h0,         exp: 32'h8C22_0004};

    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busyA}, 32'd0);
    chk("rst_gnt", {30'd0, g1A, g0A}, 32'd0);
    chk("rst_rvalid", {30'd0, v1A, v0A}, 32'd0);
    chk("rst_mem_we", {31'd0, mweA}, 32'd0);
    chk("rst_mem_adr", madrA, 32'd0);
    chk("rst_mem_wd", mwdA, 32'd0);
    chk("rst_rdata", rdA, 32'd0);
    rstA = 1'b0; rstB = 1'b0;

    for (int i = 0; i < 6; i++) access_a(i, tbl[i]);

    // Both requesters held continuously: strict 0,1,0,1 alternation.
    reset_a();
    q0A = 1'b1; q1A = 1'b1; w0A = 1'b0; w1A = 1'b0; a0A = 32'h40; a1A = 32'h80;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (g0A || g1A) begin
          got = 1'b1;
          chk($sformatf("rr%0d_one_gnt", k), {31'd0, g0A & g1A}, 32'd0);
          chk($sformatf("rr%0d_port", k), {31'd0, g1A}, (k % 2 == 1) ? 32'd1 : 32'd0);
        end
      end
      chk($sformatf("rr%0d_gnt_seen", k), {31'd0, got}, 32'd1);
    end
    q0A = 1'b0; q1A = 1'b0;
    repeat (4) @(negedge clk);
    chk("rr_idle", {31'd0, busyA}, 32'd0);

    // Instance B: RD_LAT=3 read, rvalid exactly in cycle 5.
    @(negedge clk);
    q0B = 1'b1; w0B = 1'b0; a0B = 32'h40;
    @(negedge clk);
    chk("lat_gnt", {30'd0, g1B, g0B}, 32'd1);
    chk("lat_adr_c1", madrB, 32'h40);
    q0B = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("lat_c%0d_rvalid", c), {30'd0, v1B, v0B}, 32'd0);
      chk($sformatf("lat_c%0d_adr", c), madrB, 32'h40);
      chk($sformatf("lat_c%0d_we", c), {31'd0, mweB}, 32'd0);
      chk($sformatf("lat_c%0d_busy", c), {31'd0, busyB}, 32'd1);
    end
    @(negedge clk);
    chk("lat_rvalid", {30'd0, v1B, v0B}, 32'd1);
    chk("lat_rdata", rdB, 32'h8C22_0004);
    @(negedge clk);
    chk("lat_rvalid_pulse", {30'd0, v1B, v0B}, 32'd0);

    // Reset during WAIT aborts the access without any pulse.
    @(negedge clk);
    q0B = 1'b1; a0B = 32'h80;
    @(negedge clk);
    chk("abort_gnt", {30'd0, g1B, g0B}, 32'd1);
    q0B = 1'b0;
    @(negedge clk);
    rstB = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busyB}, 32'd0);
    chk("abort_rvalid", {30'd0, v1B, v0B}, 32'd0);
    chk("abort_adr", madrB, 32'd0);
    chk("abort_rdata", rdB, 32'd0);
    rstB = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (v0B || v1B || g0B || g1B) seen++;
    end
    chk("abort_no_pulse", seen, 32'd0);
    q1B = 1'b1; w1B = 1'b0; a1B = 32'h80;
    @(negedge clk);
    chk("post_gnt1", {30'd0, g1B, g0B}, 32'd2);
    q1B = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_no_early", {30'd0, v1B, v0B}, 32'd0);
    @(negedge clk);
    chk("post_rvalid1", {30'd0, v1B, v0B}, 32'd2);
    chk("post_rdata", rdB, 32'h0BAD_F00D);

`ifdef MEM_ARBITER_STATS_EN
    reset_a();
    chk("st_rst_gcnt0", {30'd0, gc0A}, 32'd0);
    chk("st_rst_conflict", {30'd0, cfA}, 32'd0);
    for (int i = 0; i < 5; i++) access_a(10 + i, tbl[0]);
    chk("st_gcnt0_sat", {30'd0, gc0A}, 32'd3);
    chk("st_gcnt1_zero", {30'd0, gc1A}, 32'd0);
    chk("st_conflict_zero", {30'd0, cfA}, 32'd0);
    @(negedge clk);
    q0A = 1'b1; q1A = 1'b1; w0A = 1'b0; w1A = 1'b0; a0A = 32'h40; a1A = 32'h80;
    @(negedge clk);
    chk("st_both_gnt1", {30'd0, g1A, g0A}, 32'd2);
    chk("st_conflict_one", {30'd0, cfA}, 32'd1);
    q1A = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (g0A) got = 1'b1;
    end
    chk("st_loser_gnt0", {31'd0, got}, 32'd1);
    q0A = 1'b0;
    repeat (3) @(negedge clk);
    chk("st_conflict_hold", {30'd0, cfA}, 32'd1);
    chk("st_gcnt1_one", {30'd0, gc1A}, 32'd1);
    chk("st_gcnt0_hold", {30'd0, gc0A}, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
